mul_unit: RTL and testbench

Two-stage pipelined RISC-V M-extension multiply unit. It accepts MUL/MULH/MULHSU/MULHU operations from the execute stage over a valid/ready handshake and registers the operands. It drives the team's combinational signed `booth_multiplier` (32x32 -> 64) from those registers, applies unsigned/mixed-sign correction to the high word, and returns a 32-bit result with its destination tag to writeback over a second valid/ready handshake.

---
 rtl/mul_pkg.sv | 14 +
 rtl/booth_multiplier.sv | 38 +++
 rtl/mul_unit.sv | 112 +++++++++++
 tb/tb_mul_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the RISC-V M-extension multiply unit.
// Operation encodings match the low two funct3 bits of the MUL* instructions.
package mul_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [1:0] mul_op_t;

  localparam mul_op_t MUL_OP_MUL    = 2'b00;
  localparam mul_op_t MUL_OP_MULH   = 2'b01;
  localparam mul_op_t MUL_OP_MULHSU = 2'b10;
  localparam mul_op_t MUL_OP_MULHU  = 2'b11;

endpackage

// File: rtl/booth_multiplier.sv
// Combinational signed 32x32 -> 64 multiplier using radix-4 Booth recoding.
// Both operands are treated as two's complement.
module booth_multiplier
  import mul_pkg::*;
(
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] p_o
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] pp;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     b_ext;
  logic [2:0]        trip;

  always_comb begin
    a_ext = {{XLEN{a_i[XLEN-1]}}, a_i};
    b_ext = {b_i, 1'b0};
    acc   = '0;
    pp    = '0;
    trip  = '0;
    // Each overlapping bit triplet of b selects one of {0, +-a, +-2a}.
    for (int i = 0; i < XLEN / 2; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    p_o = acc;
  end

endmodule

// File: rtl/mul_unit.sv
// Two-stage elastic multiply unit: S1 holds operands, S2 holds the corrected result.
// Unsigned and mixed-sign high words are derived from the signed product.
module mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd
);

  logic             v1_q, v1_d;
  mul_op_t          op1_q;
  logic [XLEN-1:0]  a1_q, b1_q;
  logic [TAG_W-1:0] rd1_q;

  logic             v2_q, v2_d;
  logic [TAG_W-1:0] rd2_q;
  logic [XLEN-1:0]  res2_q;

  logic             adv2;
  logic             accept;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  hi, corr_a, corr_b, res_sel;

  booth_multiplier u_booth (
    .a_i (a1_q),
    .b_i (b1_q),
    .p_o (prod)
  );

  assign adv2     = v1_q && (!v2_q || out_ready);
  assign in_ready = !v1_q || adv2;
  assign accept   = in_valid && in_ready && !flush;

  // A negative operand read as unsigned adds 2^32 times the other operand.
  always_comb begin
    hi      = prod[2*XLEN-1:XLEN];
    corr_a  = b1_q[XLEN-1] ? a1_q : '0;
    corr_b  = a1_q[XLEN-1] ? b1_q : '0;
    res_sel = '0;
    unique case (op1_q)
      MUL_OP_MUL:    res_sel = prod[XLEN-1:0];
      MUL_OP_MULH:   res_sel = hi;
      MUL_OP_MULHSU: res_sel = hi + corr_a;
      MUL_OP_MULHU:  res_sel = hi + corr_a + corr_b;
      default:       res_sel = '0;
    endcase
  end

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (accept) begin
        v1_d = 1'b1;
      end else if (adv2) begin
        v1_d = 1'b0;
      end
      if (adv2) begin
        v2_d = 1'b1;
      end else if (v2_q && out_ready) begin
        v2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      op1_q  <= MUL_OP_MUL;
      a1_q   <= '0;
      b1_q   <= '0;
      rd1_q  <= '0;
      v2_q   <= 1'b0;
      rd2_q  <= '0;
      res2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (accept) begin
        op1_q <= in_op;
        a1_q  <= in_a;
        b1_q  <= in_b;
        rd1_q <= in_rd;
      end
      if (adv2 && !flush) begin
        rd2_q  <= rd1_q;
        res2_q <= res_sel;
      end
    end
  end

  assign out_valid  = v2_q;
  assign out_result = res2_q;
  assign out_rd     = rd2_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed latency/backpressure/flush/reset cases
// followed by a randomised traffic phase.
module tb_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  mul_unit #(
    .TAG_W (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: extend each operand per its signedness and take a 64-bit product.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: consume on output transfer, then discard on flush or record acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_rd", 32'(out_rd), 32'(e.rd));
          check_eq("sb_result", out_result, e.res);
          n_out++;
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.rd  = in_rd;
        e.res = ref_mul(in_op, in_a, in_b);
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [1:0]  hw_op  [4];
  logic [31:0] hw_a   [4];
  logic [31:0] hw_b   [4];
  logic [31:0] hw_exp [4];

  initial begin
    hw_op[0] = 2'b01; hw_a[0] = 32'h8000_0000; hw_b[0] = 32'h8000_0000; hw_exp[0] = 32'h4000_0000;
    hw_op[1] = 2'b11; hw_a[1] = 32'hFFFF_FFFF; hw_b[1] = 32'hFFFF_FFFF; hw_exp[1] = 32'hFFFF_FFFE;
    hw_op[2] = 2'b10; hw_a[2] = 32'hFFFF_FFFF; hw_b[2] = 32'hFFFF_FFFF; hw_exp[2] = 32'hFFFF_FFFF;
    hw_op[3] = 2'b00; hw_a[3] = 32'd12345;     hw_b[3] = 32'hFFFF_FF00; hw_exp[3] = 32'hFFCF_C700;

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_out_rd", 32'(out_rd), 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // MUL latency: visible after exactly two edges.
    drive(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check_eq("mul_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("mul_lat1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_eq("mul_lat2_valid", {31'b0, out_valid}, 32'd1);
    check_eq("mul_result", out_result, 32'hFFFF_FFEB);
    check_eq("mul_rd", 32'(out_rd), 32'd5);
    tick();
    check_eq("mul_done_valid", {31'b0, out_valid}, 32'd0);

    // Back-to-back high-word ops, tags 1..4.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(hw_op[i], hw_a[i], hw_b[i], 5'(i + 1));
      else in_valid = 1'b0;
      if (i >= 2 && i < 6) begin
        check_eq("b2b_valid", {31'b0, out_valid}, 32'd1);
        check_eq("b2b_rd", 32'(out_rd), 32'(i - 1));
        check_eq("b2b_result", out_result, hw_exp[i-2]);
      end else begin
        check_eq("b2b_idle_valid", {31'b0, out_valid}, 32'd0);
      end
      tick();
    end

    // Backpressure: two held, third stalls until out_ready rises.
    out_ready = 1'b0;
    drive(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10);
    tick();
    drive(2'b10, 32'h8765_4321, 32'h8000_0001, 5'd11);
    check_eq("bp_second_ready", {31'b0, in_ready}, 32'd1);
    tick();
    drive(2'b11, 32'd3, 32'd5, 5'd12);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_stall_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    drain();
    check_eq("bp_delivered", 32'(n_out), 32'd8);

    // Flush with S1/S2 full and a new op presented the same cycle.
    out_ready = 1'b0;
    drive(2'b00, 32'd100, 32'd3, 5'd20);
    tick();
    drive(2'b00, 32'd200, 32'd3, 5'd21);
    tick();
    drive(2'b00, 32'd300, 32'd3, 5'd22);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_valid", {31'b0, out_valid}, 32'd0);
    drive(2'b00, 32'd6, 32'd7, 5'd23);
    tick();
    in_valid = 1'b0;
    check_eq("flush_after1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_eq("flush_after2_valid", {31'b0, out_valid}, 32'd1);
    check_eq("flush_after_rd", 32'(out_rd), 32'd23);
    check_eq("flush_after_result", out_result, 32'd42);
    tick();
    check_eq("flush_drained_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while S2 holds a result.
    out_ready = 1'b0;
    drive(2'b00, 32'd3, 32'd5, 5'd30);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("arst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("arst_result", out_result, 32'd0);
    check_eq("arst_rd", 32'(out_rd), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("arst_after_valid", {31'b0, out_valid}, 32'd0);

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      in_b      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_rd     = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
